// File: rtl/conv3x3_mac_pkg.sv
// Shared types and constants for the 3x3 convolution stage that follows im2col.
// Holds the FSM encoding, the tap count and the default memory map.
package conv3x3_mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int TAPS       = 9;
  localparam int PROD_WIDTH = 17;

  localparam logic [15:0] DEF_WEIGHT_BASE = 16'h1000;
  localparam logic [15:0] DEF_IM2COL_BASE = 16'h2000;
  localparam logic [15:0] DEF_OUT_BASE    = 16'h4000;

endpackage

// File: rtl/conv3x3_mac_if.sv
// Single-port read/write memory bus shared with the im2col unit.
// The convolution engine is the master; the memory (or its model) is the slave.
interface conv3x3_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] data_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  mem_wr_en;

  modport master (
    input  data_rd,
    output addr_rd,
    output addr_wr,
    output data_wr,
    output mem_wr_en
  );

  modport slave (
    output data_rd,
    input  addr_rd,
    input  addr_wr,
    input  data_wr,
    input  mem_wr_en
  );

endinterface

// File: rtl/conv3x3_mac_mac_relu_sat.sv
// Combinational datapath: one signed multiply-accumulate step, plus the
// shift / ReLU / unsigned saturation applied to the finished sum.
module mac_relu_sat
  import conv3x3_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int SHIFT      = 0
) (
  input  logic        [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic                         first,
  output logic signed [ACC_WIDTH-1:0]  acc_next,
  output logic        [DATA_WIDTH-1:0] sat
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] MAX_OUT = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] shifted;

  // Pixel is unsigned: a leading zero bit keeps it positive in the signed multiply.
  assign prod     = $signed({1'b0, pixel}) * weight;
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  assign acc_next = (first ? '0 : acc) + prod_ext;
  assign shifted  = acc >>> SHIFT;

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    sat = '0;
    if (shifted < 0)
      sat = '0;
    else if (shifted > MAX_OUT)
      sat = '1;
    else
      sat = shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 single-channel convolution: loads nine weights, then per output pixel
// accumulates its im2col column and writes one saturated byte.
module conv3x3_mac
  import conv3x3_mac_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ACC_WIDTH  = 20,
  parameter int SHIFT      = 0,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(DEF_IM2COL_BASE),
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(DEF_WEIGHT_BASE),
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE    = ADDR_WIDTH'(DEF_OUT_BASE)
) (
  input  logic          clk,
  input  logic          rst_im2col,
  input  logic          im2col_done,
  conv3x3_mac_if.master mem,
  output logic          conv_done
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [3:0]       LAST_TAP = 4'(TAPS - 1);

  state_t                       state, state_next;
  logic [3:0]                   k, k_next;
  logic [PIX_W-1:0]             p, p_next;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next;
  logic signed [DATA_WIDTH-1:0] w [TAPS];
  logic [DATA_WIDTH-1:0]        sat;
  logic [ADDR_WIDTH-1:0]        p_ext;

  assign p_ext = ADDR_WIDTH'(p);

  mac_relu_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT)
  ) u_mac (
    .pixel   (mem.data_rd),
    .weight  (w[k]),
    .acc     (acc),
    .first   (k == 4'd0),
    .acc_next(acc_next),
    .sat     (sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the weight file is nine plain registers, not an inferred RAM, so it
  // takes the asynchronous reset together with the rest of the state.
  always_ff @(posedge clk or posedge rst_im2col) begin
    if (rst_im2col) begin
      state <= S_IDLE;
      k     <= '0;
      p     <= '0;
      acc   <= '0;
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      p     <= p_next;
      if (state == S_LOAD_W) w[k] <= mem.data_rd;
      if (state == S_MAC)    acc  <= acc_next;
    end
  end

  always_comb begin
    state_next    = state;
    k_next        = k;
    p_next        = p;
    mem.addr_rd   = IM2COL_BASE;
    mem.addr_wr   = OUT_BASE;
    mem.data_wr   = '0;
    mem.mem_wr_en = 1'b0;
    conv_done     = 1'b0;

    case (state)
      S_IDLE: begin
        if (im2col_done) begin
          state_next = S_LOAD_W;
          k_next     = '0;
          p_next     = '0;
        end
      end
      S_LOAD_W: begin
        mem.addr_rd = WEIGHT_BASE + ADDR_WIDTH'(k);
        k_next      = k + 4'd1;
        if (k == LAST_TAP) begin
          k_next     = '0;
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        // Column start 9*p formed as (p<<3)+p at full address width.
        mem.addr_rd = IM2COL_BASE + (p_ext << 3) + p_ext + ADDR_WIDTH'(k);
        k_next      = k + 4'd1;
        if (k == LAST_TAP) begin
          k_next     = '0;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem.mem_wr_en = 1'b1;
        mem.addr_wr   = OUT_BASE + p_ext;
        mem.data_wr   = sat;
        if (p == LAST_PIX) begin
          state_next = S_DONE;
        end else begin
          p_next     = p + 1'b1;
          state_next = S_MAC;
        end
      end
      S_DONE: begin
        conv_done = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: memory model, timing and reset
// sequences, then a table of hand-computed output pixels.
module tb_conv3x3_mac;

  localparam logic [31:0] WB = 32'h1000;
  localparam logic [31:0] IB = 32'h2000;
  localparam logic [31:0] OB = 32'h4000;

  typedef struct {
    string name;
    int    scen;
    int    dut;
    int    pix;
    int    exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_im2col = 1'b1;
  logic done0 = 1'b0;
  logic done1 = 1'b0;
  logic conv_done0, conv_done1;

  logic [7:0] mem [0:65535];
  logic [7:0] out_mem [0:63];
  int wr_count = 0;

  int total = 0;
  int passed = 0;

  conv3x3_mac_if bus0 ();
  conv3x3_mac_if bus1 ();

  assign bus0.data_rd = mem[bus0.addr_rd[15:0]];
  assign bus1.data_rd = mem[bus1.addr_rd[15:0]];

  conv3x3_mac dut0 (
    .clk        (clk),
    .rst_im2col (rst_im2col),
    .im2col_done(done0),
    .mem        (bus0),
    .conv_done  (conv_done0)
  );

  conv3x3_mac #(.SHIFT(2)) dut1 (
    .clk        (clk),
    .rst_im2col (rst_im2col),
    .im2col_done(done1),
    .mem        (bus1),
    .conv_done  (conv_done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus0.mem_wr_en) begin
      out_mem[6'(bus0.addr_wr - OB)] <= bus0.data_wr;
      wr_count <= wr_count + 1;
    end else if (bus1.mem_wr_en) begin
      out_mem[6'(bus1.addr_wr - OB)] <= bus1.data_wr;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int img_pix(input int scen, input int r, input int c);
    if (r < 0 || r > 7 || c < 0 || c > 7) return 0;
    return (scen == 0) ? r * 8 + c : 10;
  endfunction

  // Scenarios: 0 identity/ramp, 1 and 4 box/const 10, 2 w=127/taps 255, 3 w=-1/taps 5.
  task automatic setup(input int scen);
    for (int k = 0; k < 9; k++) begin
      case (scen)
        0:       mem[16'(WB + 32'(k))] = (k == 4) ? 8'd1 : 8'd0;
        2:       mem[16'(WB + 32'(k))] = 8'd127;
        3:       mem[16'(WB + 32'(k))] = 8'hFF;
        default: mem[16'(WB + 32'(k))] = 8'd1;
      endcase
    end
    for (int p = 0; p < 64; p++) begin
      for (int k = 0; k < 9; k++) begin
        case (scen)
          2:       mem[16'(IB + 32'(9 * p + k))] = 8'd255;
          3:       mem[16'(IB + 32'(9 * p + k))] = 8'd5;
          default: mem[16'(IB + 32'(9 * p + k))] =
                     8'(img_pix(scen, p / 8 + k / 3 - 1, p % 8 + k % 3 - 1));
        endcase
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_im2col = 1'b1;
    repeat (2) @(negedge clk);
    rst_im2col = 1'b0;
  endtask

  task automatic run(input int dut, input string name);
    int start;
    int i;
    do_reset();
    start = wr_count;
    if (dut == 0) done0 = 1'b1; else done1 = 1'b1;
    @(negedge clk);
    done0 = 1'b0;
    done1 = 1'b0;
    for (i = 0; i < 1000; i++) begin
      if ((dut == 0 && conv_done0) || (dut == 1 && conv_done1)) break;
      @(negedge clk);
    end
    check({name, " completes"}, 32'(i < 1000), 32'd1);
    check({name, " write count"}, 32'(wr_count - start), 32'd64);
  endtask

  vec_t vecs[17];

  initial begin
    int first_w, last_w_addr, first_wr, first_done, overlap, start, cur, i;

    vecs[0]  = '{"ident p0",      0, 0, 0,  0};
    vecs[1]  = '{"ident p37",     0, 0, 37, 37};
    vecs[2]  = '{"ident p63",     0, 0, 63, 63};
    vecs[3]  = '{"box corner p0", 1, 0, 0,  40};
    vecs[4]  = '{"box corner p7", 1, 0, 7,  40};
    vecs[5]  = '{"box edge p3",   1, 0, 3,  60};
    vecs[6]  = '{"box edge p24",  1, 0, 24, 60};
    vecs[7]  = '{"box inner p27", 1, 0, 27, 90};
    vecs[8]  = '{"box corner p63",1, 0, 63, 40};
    vecs[9]  = '{"sat p0",        2, 0, 0,  255};
    vecs[10] = '{"sat p45",       2, 0, 45, 255};
    vecs[11] = '{"relu p0",       3, 0, 0,  0};
    vecs[12] = '{"relu p63",      3, 0, 63, 0};
    vecs[13] = '{"shift2 inner",  4, 1, 27, 22};
    vecs[14] = '{"shift2 corner", 4, 1, 0,  10};
    vecs[15] = '{"shift2 edge",   4, 1, 3,  15};
    vecs[16] = '{"shift2 p36",    4, 1, 36, 22};

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst addr_rd",   bus0.addr_rd,   IB);
    check("rst addr_wr",   bus0.addr_wr,   OB);
    check("rst data_wr",   32'(bus0.data_wr), 32'd0);
    check("rst mem_wr_en", 32'(bus0.mem_wr_en), 32'd0);
    check("rst conv_done", 32'(conv_done0), 32'd0);

    // Timing: start sampled at edge 0, one-cycle pulse on im2col_done.
    setup(0);
    do_reset();
    start = wr_count;
    done0 = 1'b1;
    @(posedge clk);
    first_w = -1; last_w_addr = 0; first_wr = -1; first_done = -1; overlap = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 1) done0 = 1'b0;
      if (first_w < 0 && bus0.addr_rd == WB) first_w = c;
      if (c == 9) last_w_addr = int'(bus0.addr_rd);
      if (first_wr < 0 && bus0.mem_wr_en) first_wr = c;
      if (bus0.mem_wr_en && bus0.addr_rd != IB) overlap++;
      if (first_done < 0 && conv_done0) first_done = c;
    end
    check("first weight read cycle", 32'(first_w), 32'd1);
    check("last weight addr cycle 9", 32'(last_w_addr), WB + 32'd8);
    check("first write cycle", 32'(first_wr), 32'd19);
    check("conv_done cycle", 32'(first_done), 32'd650);
    check("read during write", 32'(overlap), 32'd0);
    check("timing run writes", 32'(wr_count - start), 32'd64);
    check("timing out p5", 32'(out_mem[5]), 32'd5);

    // Reset during pixel 20 MAC aborts at once and leaves 20 outputs written.
    do_reset();
    start = wr_count;
    done0 = 1'b1;
    @(negedge clk);
    done0 = 1'b0;
    for (i = 0; i < 1000; i++) begin
      if (bus0.addr_rd == IB + 32'(9 * 20 + 4)) break;
      @(negedge clk);
    end
    check("reach pixel 20", 32'(i < 1000), 32'd1);
    rst_im2col = 1'b1;
    #1;
    check("abort addr_rd",   bus0.addr_rd,   IB);
    check("abort addr_wr",   bus0.addr_wr,   OB);
    check("abort data_wr",   32'(bus0.data_wr), 32'd0);
    check("abort mem_wr_en", 32'(bus0.mem_wr_en), 32'd0);
    repeat (3) @(negedge clk);
    rst_im2col = 1'b0;
    repeat (50) @(negedge clk);
    check("abort writes", 32'(wr_count - start), 32'd20);
    check("abort stays idle", bus0.addr_rd, IB);
    check("abort conv_done", 32'(conv_done0), 32'd0);

    // Table of output pixels; a fresh run whenever the scenario changes.
    cur = -1;
    for (int v = 0; v < 17; v++) begin
      if (vecs[v].scen != cur) begin
        cur = vecs[v].scen;
        setup(cur);
        run(vecs[v].dut, $sformatf("scen%0d", cur));
      end
      check(vecs[v].name, 32'(out_mem[vecs[v].pix]), 32'(vecs[v].exp));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
